pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//   Multi-phase fetch/execute controller for the RV32I core: owns the PC, runs the valid/ready fetch handshake to
//   instruction memory, latches the fetched word for decode and immediate generation, and qualifies execution.
//   Takes the decoded immediate and ALU compare result back in, selects the next PC and halts on SYSTEM/illegal opcodes.
// PARAMETERS
//   XLEN             32            PC / address width
//   RESET_PC         32'h0000_0000 PC value loaded on reset
//   HALT_ON_ILLEGAL  1             1: unknown opcode or misaligned target -> HALT; 0: treat as NOP (pc+4)
// PORTS
//   clk             in   1     core clock
//   rst_n           in   1     asynchronous active-low reset
//   imem_req_valid  out  1     fetch request valid
//   imem_req_ready  in   1     instruction memory accepts request
//   imem_addr       out  XLEN  fetch address (== pc)
//   imem_rsp_valid  in   1     instruction word valid
//   imem_rsp_data   in   32    instruction word
//   instr           out  32    latched instruction, feeds decode and immediate generator
//   instr_valid     out  1     high in every EXEC cycle
//   imm             in   32    sign-extended immediate for instr (combinational from immediate generator)
//   branch_taken    in   1     ALU branch-compare result, sampled in EXEC
//   dmem_busy       in   1     data memory stall; holds EXEC
//   wb_en           out  1     register-file write qualifier: final EXEC cycle, opcode in {0000011,0010011,0110011}
//   pc              out  XLEN  current PC
//   halted          out  1     sticky, set on entry to HALT
// BEHAVIOUR
//   One clock; reset is asynchronous and active-low. Reset: state=IDLE, pc=RESET_PC, instr=0, all other outputs 0.
//   FSM: IDLE -> FETCH (unconditionally, 1 cycle after reset release).
//     FETCH: imem_req_valid=1, imem_addr=pc; leave to WAIT on req_valid&&req_ready.
//     WAIT: on imem_rsp_valid latch instr, -> EXEC. rsp_valid outside WAIT ignored; imem shares rst_n (no stale rsp).
//     EXEC: instr_valid=1; stays while dmem_busy. Final cycle (dmem_busy=0) updates pc and -> FETCH, or -> HALT.
//     HALT: terminal until reset; imem_req_valid=0, pc frozen, halted=1.
//   Best-case latency 3 cycles/instr (FETCH, WAIT, EXEC) with zero-wait memory.
//   Next PC (final EXEC cycle): opcode 1100011 && branch_taken -> pc+imm; else pc+4. Arithmetic mod 2^XLEN:
//     pc=32'hFFFF_FFFC +4 -> 0, no flag. Target[1:0]!=0 -> HALT if HALT_ON_ILLEGAL else pc+4.
//   Opcode 1110011 (SYSTEM) -> HALT, pc not updated. Unknown opcode: HALT_ON_ILLEGAL=1 -> HALT; 0 -> NOP, pc+4.
//   wb_en never asserted for 0100011, 1100011, 1110011 or an illegal instruction.
//   Reset mid-FETCH/WAIT/EXEC: immediate return to IDLE, pc=RESET_PC; no wb_en, no pc update that cycle.
// CONFIGURATION
//   PC_SEQ_PERF_EN defined: extra outputs retired_cnt[31:0] (+1 per completed EXEC incl. NOP, excl. HALT entry)
//     and branch_cnt[31:0] (+1 per taken branch); both reset to 0, wrap at 2^32.
//   Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//   rv_core_pkg: state enum (IDLE,FETCH,WAIT,EXEC,HALT); opcode localparams OP_LOAD, OP_IMM, OP_STORE,
//     OP_BRANCH, OP_REG, OP_SYSTEM (shared with the immediate generator and decoder).
//   Sub-module pc_seq_next_pc: combinational pc+4 / pc+imm select and alignment check.
// TESTING
//   Reset release, ready=1, zero-wait rsp -> first imem_addr=0x0, req_valid in cycle 2, instr_valid in cycle 4.
//   addi (0x00500093) at 0x0 -> wb_en pulse 1 cycle, next fetch addr 0x4.
//   beq imm=+8 at 0x10, branch_taken=1 -> next addr 0x18; branch_taken=0 -> 0x14; no wb_en.
//   req_ready low 3 cycles, dmem_busy 2 cycles on sw -> req_valid and imem_addr held stable, EXEC lasts 3 cycles, wb_en=0.
//   ecall (0x00000073) -> halted=1, req_valid stays 0 for 20 cycles, pc frozen; illegal 0xFFFFFFFF same when HALT_ON_ILLEGAL=1.
//   pc=0xFFFF_FFFC addi -> next fetch 0x0; rst_n low during WAIT -> pc=RESET_PC, state IDLE next edge.

Source files
------------

// File: rtl/rv_core_pkg.sv
// Shared RV32I core definitions: sequencer states and the opcodes used by
// the sequencer, decoder and immediate generator.
package rv_core_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EXEC,
        HALT
    } pc_state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    function automatic logic op_known(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_IMM) || (op == OP_STORE) ||
               (op == OP_BRANCH) || (op == OP_REG) || (op == OP_SYSTEM);
    endfunction

    // Opcodes that produce a register-file result
    function automatic logic op_writes_rd(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_IMM) || (op == OP_REG);
    endfunction

endpackage

// File: rtl/pc_seq_next_pc.sv
// Next-PC datapath: sequential pc+4 and branch pc+imm select, with an
// alignment check on the selected target. Arithmetic wraps mod 2^XLEN.
module pc_seq_next_pc #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     imm,
    input  logic            take_branch,
    output logic [XLEN-1:0] seq_pc,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic signed [XLEN-1:0] imm_ext;

    assign imm_ext    = XLEN'($signed(imm));
    assign seq_pc     = pc + XLEN'(4);
    assign target     = take_branch ? (pc + imm_ext) : seq_pc;
    assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for the RV32I core: owns the PC, runs the imem
// handshake, latches the instruction and retires it. Optional perf counters
// (retired_cnt, branch_cnt) are built when PC_SEQ_PERF_EN is defined.
module pc_sequencer
    import rv_core_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter bit              HALT_ON_ILLEGAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic [31:0]     imm,
    input  logic            branch_taken,
    input  logic            dmem_busy,
    output logic            wb_en,
    output logic [XLEN-1:0] pc,
    output logic            halted
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0]     retired_cnt,
    output logic [31:0]     branch_cnt
`endif
);

    pc_state_e       state, state_nx;
    logic [6:0]      opcode;
    logic            take_branch;
    logic            exec_done;
    logic            illegal;
    logic            halt_now;
    logic            retire;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] target;
    logic            misaligned;

    assign opcode      = instr[6:0];
    assign take_branch = (opcode == OP_BRANCH) && branch_taken;
    assign exec_done   = (state == EXEC) && !dmem_busy;
    // pc+4 from an aligned pc is always aligned, so misalignment only comes from a taken branch
    assign illegal     = !op_known(opcode) || misaligned;
    assign halt_now    = (opcode == OP_SYSTEM) || (HALT_ON_ILLEGAL && illegal);
    assign retire      = exec_done && !halt_now;

    pc_seq_next_pc #(.XLEN(XLEN)) u_next_pc (
        .pc          (pc),
        .imm         (imm),
        .take_branch (take_branch),
        .seq_pc      (seq_pc),
        .target      (target),
        .misaligned  (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        case (state)
            IDLE:  state_nx = FETCH;
            FETCH: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) state_nx = WAIT;
            end
            WAIT:  if (imem_rsp_valid) state_nx = EXEC;
            EXEC: begin
                instr_valid = 1'b1;
                if (exec_done) state_nx = halt_now ? HALT : FETCH;
            end
            HALT:  state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            if ((state == WAIT) && imem_rsp_valid) instr <= imem_rsp_data;
            // A misaligned target only survives to here with HALT_ON_ILLEGAL=0: fall through to pc+4
            if (retire) pc <= misaligned ? seq_pc : target;
        end
    end

    assign imem_addr = pc;
    assign wb_en     = exec_done && op_writes_rd(opcode);
    assign halted    = (state == HALT);

`ifdef PC_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
            branch_cnt  <= '0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + 32'd1;
            if (take_branch && !misaligned) branch_cnt <= branch_cnt + 32'd1;
        end
    end
`endif

endmodule
